// File: rtl/riscv_mem_arbiter_pkg.sv
// rtl/riscv_mem_arbiter_pkg.sv - shared message sizes, port IDs and arbiter state type
package riscv_mem_arbiter_pkg;
  localparam int VC_MEM_REQ_MSG_SZ  = 67;
  localparam int VC_MEM_RESP_MSG_SZ = 35;

  localparam logic ARB_PORT_IMEM = 1'b0;
  localparam logic ARB_PORT_DMEM = 1'b1;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_e;
endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - val/rdy memory message channel
interface riscv_mem_arbiter_if
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int p_msg_sz = VC_MEM_REQ_MSG_SZ
) ();
  logic                val;
  logic                rdy;
  logic [p_msg_sz-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/riscv_mem_arbiter_tagq.sv
// rtl/riscv_mem_arbiter_tagq.sv - in-order owner tag FIFO for outstanding requests
module riscv_mem_arbiter_tagq #(
  parameter int p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic push_tag_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int AW = $clog2(p_depth);

  logic [p_depth-1:0] tags_q;
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tags_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        tags_q[wptr_q] <= push_tag_i;
        wptr_q         <= wptr_q + AW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + AW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign full_o  = (cnt_q == (AW+1)'(p_depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = tags_q[rptr_q];
endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin imem/dmem arbiter onto one memory port
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int p_req_sz   = VC_MEM_REQ_MSG_SZ,
  parameter int p_resp_sz  = VC_MEM_RESP_MSG_SZ,
  parameter int p_max_outs = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_mem_arbiter_if.slave   req0,
  riscv_mem_arbiter_if.slave   req1,
  riscv_mem_arbiter_if.master  resp0,
  riscv_mem_arbiter_if.master  resp1,
  riscv_mem_arbiter_if.master  memreq,
  riscv_mem_arbiter_if.slave   memresp,
  output logic [31:0]          grant_cnt0,
  output logic [31:0]          grant_cnt1,
  output logic                 err
);
  arb_state_e state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic hold_grant_q, hold_grant_d;
  logic grant, grant_val, req_fire, resp_fire;
  logic full, empty, head;
  logic [p_req_sz-1:0]  req_msg;
  logic [p_resp_sz-1:0] resp_msg;
  logic [31:0] grant_cnt0_q, grant_cnt1_q;
  logic err_q;

  // A held grant is frozen; otherwise a lone requester wins and ties go to the port not granted last.
  always_comb begin
    grant = ~last_grant_q;
    if (state_q == HOLD)              grant = hold_grant_q;
    else if (req0.val && !req1.val)   grant = ARB_PORT_IMEM;
    else if (req1.val && !req0.val)   grant = ARB_PORT_DMEM;
  end

  assign grant_val  = (grant == ARB_PORT_DMEM) ? req1.val : req0.val;
  assign req_msg    = (grant == ARB_PORT_DMEM) ? req1.msg : req0.msg;
  assign memreq.msg = req_msg;
  assign memreq.val = grant_val && !full;
  assign req0.rdy   = (grant == ARB_PORT_IMEM) && memreq.rdy && !full;
  assign req1.rdy   = (grant == ARB_PORT_DMEM) && memreq.rdy && !full;
  assign req_fire   = memreq.val && memreq.rdy;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_grant_d = hold_grant_q;
    case (state_q)
      IDLE: if (grant_val && !req_fire) begin
        state_d      = HOLD;
        hold_grant_d = grant;
      end
      HOLD: if (req_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req_fire) last_grant_d = grant;
  end

  assign resp_msg    = memresp.msg;
  assign resp0.msg   = resp_msg;
  assign resp1.msg   = resp_msg;
  assign resp0.val   = memresp.val && !empty && (head == ARB_PORT_IMEM);
  assign resp1.val   = memresp.val && !empty && (head == ARB_PORT_DMEM);
  assign memresp.rdy = !empty && ((head == ARB_PORT_DMEM) ? resp1.rdy : resp0.rdy);
  assign resp_fire   = memresp.val && memresp.rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_PORT_DMEM;
      hold_grant_q <= ARB_PORT_IMEM;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_grant_q <= hold_grant_d;
      if (req_fire && grant == ARB_PORT_IMEM) grant_cnt0_q <= grant_cnt0_q + 32'd1;
      if (req_fire && grant == ARB_PORT_DMEM) grant_cnt1_q <= grant_cnt1_q + 32'd1;
      if (memresp.val && empty)               err_q        <= 1'b1;
    end
  end

  riscv_mem_arbiter_tagq #(.p_depth(p_max_outs)) u_tagq (
    .clk        (clk),
    .reset      (reset),
    .push_i     (req_fire),
    .push_tag_i (grant),
    .pop_i      (resp_fire),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head)
  );

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign err        = err_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;
  localparam int RQ = VC_MEM_REQ_MSG_SZ;
  localparam int RS = VC_MEM_RESP_MSG_SZ;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] grant_cnt0, grant_cnt1;
  logic err;

  riscv_mem_arbiter_if #(.p_msg_sz(RQ)) req0_if ();
  riscv_mem_arbiter_if #(.p_msg_sz(RQ)) req1_if ();
  riscv_mem_arbiter_if #(.p_msg_sz(RS)) resp0_if ();
  riscv_mem_arbiter_if #(.p_msg_sz(RS)) resp1_if ();
  riscv_mem_arbiter_if #(.p_msg_sz(RQ)) memreq_if ();
  riscv_mem_arbiter_if #(.p_msg_sz(RS)) memresp_if ();

  riscv_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0_if), .req1(req1_if), .resp0(resp0_if), .resp1(resp1_if),
    .memreq(memreq_if), .memresp(memresp_if),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err(err)
  );

  always #5 clk = ~clk;

  logic [RQ-1:0] exp_req[$];
  logic [RS-1:0] exp_r0[$];
  logic [RS-1:0] exp_r1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [RQ-1:0] act, input logic [RQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RQ-1:0] rd_msg(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [RS-1:0] rd_resp(input logic [31:0] addr);
    return {1'b0, 2'b00, addr + 32'h1000_0000};
  endfunction

  // Memory stub: in-order responses, data = addr + 0x1000_0000.
  typedef struct { logic [RS-1:0] msg; int rdy_at; } ment_t;
  ment_t mem_q[$];
  int cyc = 0;
  int mem_max = 0;
  bit mem_hold = 0, mem_inject = 0, mem_flush = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : memory
    bit rf, qf;
    logic [RQ-1:0] qm;
    memresp_if.val = 1'b0;
    memresp_if.msg = '0;
    forever begin
      @(negedge clk);
      rf = memresp_if.val && memresp_if.rdy;
      qf = memreq_if.val && memreq_if.rdy;
      qm = memreq_if.msg;
      if (mem_flush) begin mem_q.delete(); rf = 0; qf = 0; end
      @(posedge clk); #1;
      if (rf && mem_q.size() > 0) mem_q.delete(0);
      if (qf) mem_q.push_back('{msg: {1'b0, 2'b00, qm[65:34] + 32'h1000_0000},
                                rdy_at: cyc + int'($urandom_range(0, mem_max))});
      if (mem_inject) begin
        memresp_if.val = 1'b1; memresp_if.msg = 35'h7;
      end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].rdy_at <= cyc) begin
        memresp_if.val = 1'b1; memresp_if.msg = mem_q[0].msg;
      end else begin
        memresp_if.val = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        if (memreq_if.val && memreq_if.rdy) begin
          if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL memreq_unexpected: got %h expected no request", memreq_if.msg);
          end else chk("memreq_msg", memreq_if.msg, exp_req.pop_front());
        end
        if (resp0_if.val && resp0_if.rdy) begin
          if (exp_r0.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp0_unexpected: got %h expected no response", resp0_if.msg);
          end else chk("resp0_msg", RQ'(resp0_if.msg), RQ'(exp_r0.pop_front()));
        end
        if (resp1_if.val && resp1_if.rdy) begin
          if (exp_r1.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp1_unexpected: got %h expected no response", resp1_if.msg);
          end else chk("resp1_msg", RQ'(resp1_if.msg), RQ'(exp_r1.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_flush = 1'b1;
    exp_req.delete(); exp_r0.delete(); exp_r1.delete();
    tick(); tick();
    reset = 1'b1; mem_flush = 1'b0;
  endtask

  task automatic send(input int port, input logic [31:0] addr);
    int n;
    n = 0;
    exp_req.push_back(rd_msg(addr));
    if (port == 0) begin
      req0_if.val = 1'b1; req0_if.msg = rd_msg(addr); exp_r0.push_back(rd_resp(addr));
    end else begin
      req1_if.val = 1'b1; req1_if.msg = rd_msg(addr); exp_r1.push_back(rd_resp(addr));
    end
    forever begin
      @(negedge clk);
      if (port == 0 ? req0_if.rdy : req1_if.rdy) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: port %0d addr %h not accepted, expected acceptance", port, addr);
        break;
      end
    end
    tick();
    if (port == 0) req0_if.val = 1'b0; else req1_if.val = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_req.size() + exp_r0.size() + exp_r1.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_drain: %0d transactions pending, expected 0", name,
               exp_req.size() + exp_r0.size() + exp_r1.size());
    end
  endtask

  initial begin : stimulus
    int i0, i1, fires, n;
    bit f0, f1, popped;
    logic [RQ-1:0] a_msg;
    reset = 1'b0;
    req0_if.val = 1'b0; req0_if.msg = '0;
    req1_if.val = 1'b0; req1_if.msg = '0;
    resp0_if.rdy = 1'b1; resp1_if.rdy = 1'b1;
    memreq_if.rdy = 1'b1;

    // Reset state and the cycle after.
    tick();
    @(negedge clk);
    chk("rst_memreq_val", RQ'(memreq_if.val), RQ'(0));
    chk("rst_resp0_val", RQ'(resp0_if.val), RQ'(0));
    chk("rst_resp1_val", RQ'(resp1_if.val), RQ'(0));
    chk("rst_memresp_rdy", RQ'(memresp_if.rdy), RQ'(0));
    chk("rst_cnt0", RQ'(grant_cnt0), RQ'(0));
    chk("rst_cnt1", RQ'(grant_cnt1), RQ'(0));
    chk("rst_err", RQ'(err), RQ'(0));
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_memresp_rdy", RQ'(memresp_if.rdy), RQ'(0));
    chk("post_rst_err", RQ'(err), RQ'(0));

    // Single imem read at 0x100, zero-delay memory.
    tick();
    send(0, 32'h100);
    @(negedge clk);
    chk("t1_resp0_val", RQ'(resp0_if.val), RQ'(1));
    chk("t1_resp0_data", RQ'(resp0_if.msg), RQ'(35'h0_1000_0100));
    chk("t1_cnt0", RQ'(grant_cnt0), RQ'(1));
    drain("t1");

    // Both ports valid every cycle: strict alternation starting at port 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(rd_msg(32'h2000 + 32'(i * 4))); exp_r0.push_back(rd_resp(32'h2000 + 32'(i * 4)));
      exp_req.push_back(rd_msg(32'h3000 + 32'(i * 4))); exp_r1.push_back(rd_resp(32'h3000 + 32'(i * 4)));
    end
    i0 = 0; i1 = 0; fires = 0; n = 0;
    req0_if.val = 1'b1; req0_if.msg = rd_msg(32'h2000);
    req1_if.val = 1'b1; req1_if.msg = rd_msg(32'h3000);
    while (fires < 8 && n < 40) begin
      @(negedge clk);
      f0 = req0_if.val && req0_if.rdy;
      f1 = req1_if.val && req1_if.rdy;
      tick();
      if (f0) begin i0++; if (i0 < 4) req0_if.msg = rd_msg(32'h2000 + 32'(i0 * 4)); else req0_if.val = 1'b0; end
      if (f1) begin i1++; if (i1 < 4) req1_if.msg = rd_msg(32'h3000 + 32'(i1 * 4)); else req1_if.val = 1'b0; end
      fires += int'(f0) + int'(f1);
      n++;
    end
    req0_if.val = 1'b0; req1_if.val = 1'b0;
    @(negedge clk);
    chk("t2_cycles", RQ'(n), RQ'(8));
    chk("t2_cnt0", RQ'(grant_cnt0), RQ'(4));
    chk("t2_cnt1", RQ'(grant_cnt1), RQ'(4));
    drain("t2");

    // Grant held on port 0 while memreq_rdy is low and port 1 rises.
    do_reset();
    memreq_if.rdy = 1'b0;
    a_msg = rd_msg(32'h400);
    req0_if.val = 1'b1; req0_if.msg = a_msg;
    exp_req.push_back(a_msg); exp_r0.push_back(rd_resp(32'h400));
    tick();
    req1_if.val = 1'b1; req1_if.msg = rd_msg(32'h500);
    exp_req.push_back(rd_msg(32'h500)); exp_r1.push_back(rd_resp(32'h500));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_msg", memreq_if.msg, a_msg);
      chk("t3_hold_val", RQ'(memreq_if.val), RQ'(1));
      chk("t3_hold_rdy1", RQ'(req1_if.rdy), RQ'(0));
      tick();
    end
    memreq_if.rdy = 1'b1;
    @(negedge clk);
    chk("t3_rdy0", RQ'(req0_if.rdy), RQ'(1));
    tick(); req0_if.val = 1'b0;
    @(negedge clk);
    chk("t3_rdy1", RQ'(req1_if.rdy), RQ'(1));
    tick(); req1_if.val = 1'b0;
    drain("t3");

    // Four outstanding fill the tag queue; the fifth waits for the first pop.
    do_reset();
    mem_hold = 1'b1; mem_max = 4;
    send(0, 32'h600); send(1, 32'h604); send(0, 32'h608); send(1, 32'h60c);
    req0_if.val = 1'b1; req0_if.msg = rd_msg(32'h610);
    exp_req.push_back(rd_msg(32'h610)); exp_r0.push_back(rd_resp(32'h610));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_full_memreq_val", RQ'(memreq_if.val), RQ'(0));
      chk("t4_full_rdy0", RQ'(req0_if.rdy), RQ'(0));
      tick();
    end
    mem_hold = 1'b0;
    popped = 0; n = 0;
    forever begin
      @(negedge clk);
      if (req0_if.rdy) begin chk("t4_pop_before_fire", RQ'(popped), RQ'(1)); break; end
      if ((resp0_if.val && resp0_if.rdy) || (resp1_if.val && resp1_if.rdy)) popped = 1;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL t4_fifth_timeout: fifth request not accepted, expected acceptance");
        break;
      end
    end
    tick(); req0_if.val = 1'b0;
    drain("t4");
    mem_max = 0;

    // Response with nothing outstanding sets the sticky error.
    do_reset();
    mem_inject = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t5_memresp_rdy", RQ'(memresp_if.rdy), RQ'(0));
    chk("t5_resp0_val", RQ'(resp0_if.val), RQ'(0));
    tick();
    @(negedge clk);
    chk("t5_err_set", RQ'(err), RQ'(1));
    tick(); mem_inject = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t5_err_sticky", RQ'(err), RQ'(1));

    // Reset with three requests in flight clears everything.
    tick();
    mem_hold = 1'b1;
    send(0, 32'h700); send(1, 32'h704); send(0, 32'h708);
    @(negedge clk);
    chk("t6_cnt0_pre", RQ'(grant_cnt0), RQ'(2));
    chk("t6_cnt1_pre", RQ'(grant_cnt1), RQ'(1));
    do_reset();
    mem_hold = 1'b0;
    @(negedge clk);
    chk("t6_cnt0", RQ'(grant_cnt0), RQ'(0));
    chk("t6_cnt1", RQ'(grant_cnt1), RQ'(0));
    chk("t6_err", RQ'(err), RQ'(0));
    chk("t6_memresp_rdy", RQ'(memresp_if.rdy), RQ'(0));
    chk("t6_resp0_val", RQ'(resp0_if.val), RQ'(0));
    tick(); mem_inject = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t6_empty_rdy", RQ'(memresp_if.rdy), RQ'(0));
    tick(); mem_inject = 1'b0;
    do_reset();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-requester, one-memory arbiter that lets the core's instruction port (requester 0) and data port (requester 1) share a single-ported test memory or cache port. It sits between the core and the memory in the simulation harness and presents the same val/rdy memory message protocol on every side. Requests are granted round-robin. Responses are steered back to their owner through an in-order tag queue, so up to `p_max_outs` requests can be in flight.

## Interface
- `p_req_sz`, default 67: request message width (type 1, addr 32, len 2, data 32).
- `p_resp_sz`, default 35: response message width (type 1, len 2, data 32).
- `p_max_outs`, default 4: maximum outstanding requests; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req0_val` / `req0_rdy` / `req0_msg`  in / out / in  1 / 1 / p_req_sz  instruction request.
- `req1_val` / `req1_rdy` / `req1_msg`  in / out / in  1 / 1 / p_req_sz  data request.
- `resp0_val` / `resp0_rdy` / `resp0_msg`  out / in / out  1 / 1 / p_resp_sz  instruction response.
- `resp1_val` / `resp1_rdy` / `resp1_msg`  out / in / out  1 / 1 / p_resp_sz  data response.
- `memreq_val` / `memreq_rdy` / `memreq_msg`  out / in / out  1 / 1 / p_req_sz  downstream request.
- `memresp_val` / `memresp_rdy` / `memresp_msg`  in / out / in  1 / 1 / p_resp_sz  downstream response; downstream returns responses in request order.
- `grant_cnt0`, `grant_cnt1`  out  32  count of accepted requests per port.
- `err`  out  1  sticky flag: a response arrived with no outstanding tag.

## Operation
- A transfer fires on a port when that port's val and rdy are both high at the rising edge.
- Arbiter state: `IDLE` (no request presented) and `HOLD` (request presented, `memreq_rdy` low).
  - In `IDLE`, the winner is chosen combinationally:
    - If only one requester is valid, it wins.
    - If both are valid, the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie.
  - If the chosen request does not fire, go to `HOLD` and latch the grant. While in `HOLD`, the grant must not change, even if the other port asserts val. Return to `IDLE` when the request fires.
- Request forwarding:
  - `memreq_msg` is the granted port's `reqN_msg`, passed through unmodified.
  - `memreq_val` = granted `reqN_val` AND tag queue not full.
  - The granted port's `reqN_rdy` = `memreq_rdy` AND not full. The losing port's rdy is 0.
- On a request fire: push the granter ID (0/1) into the tag queue, update `last_grant`, and increment the matching `grant_cntN` (wraps modulo 2^32).
- Response routing:
  - The head tag selects the destination: `respH_val` = `memresp_val` AND not empty, with `respH_msg` = `memresp_msg`. The other resp val is 0.
  - `memresp_rdy` = selected `respH_rdy` AND not empty.
  - On a response fire, pop the tag queue.
- Boundaries:
  - Full: no request is granted, even if a pop happens in the same cycle. There is no combinational path from `memresp` to `memreq`.
  - Empty: `memresp_rdy` = 0. If `memresp_val` = 1 while empty, set `err`.
  - Simultaneous push and pop when the queue is neither full nor empty: both happen and the count is unchanged.
  - Pointers wrap modulo `p_max_outs`. The count is log2(p_max_outs)+1 bits wide.
- Reset (reset=0 at an edge), also mid-transaction:
  - Queue emptied, `HOLD` → `IDLE`, `last_grant`=1, counters=0, `err`=0.
  - All in-flight responses are abandoned. The harness resets memory at the same time.

## Timing
- Request path: zero-cycle, purely combinational from `reqN` to `memreq`. No added latency.
- Response path: zero-cycle from `memresp` to `respN`.
- State (queue, `last_grant`, hold, counters, err) updates only on the rising edge of `clk`.
- Outputs during reset and the cycle after:
  - `memreq_val`=0 unless a requester is valid.
  - All `resp*_val`=0 and `memresp_rdy`=0, because the queue is empty.
  - `grant_cnt*`=0 and `err`=0.
- Back-to-back throughput: one request fire per cycle while the queue is not full. Alternating ports is possible every cycle.

## Structure
- Shared package/header: message size macros (`VC_MEM_REQ_MSG_SZ`, `VC_MEM_RESP_MSG_SZ`) and port ID constants (`ARB_PORT_IMEM`=0, `ARB_PORT_DMEM`=1).
- Sub-module `riscv_mem_arbiter_tagq`: 1-bit-wide synchronous FIFO, depth `p_max_outs`, with push/pop/full/empty/head. Same reset as the parent.
- Top-level contents: grant FSM, muxing, and counters.

## Test plan
- Single imem read, addr 0x100, memory delay 0 → `memreq_msg` equals `req0_msg` on the same cycle; `resp0_val` 1 cycle later with the data; `grant_cnt0`=1.
- Both ports valid every cycle for 8 cycles, `memreq_rdy`=1 → grant order 0,1,0,1…; 4 grants each.
- `memreq_rdy` held low 3 cycles while `req0` is granted and `req1` rises → the grant stays on 0 until it fires, then moves to 1.
- Random-delay memory (max 4), 5 requests without responses → the 5th is blocked (`memreq_val`=0) until the first response pops; responses are routed to the correct ports.
- `memresp_val`=1 with no outstanding requests → `memresp_rdy`=0 and `err` goes to 1 and stays set.
- reset=0 asserted with 3 requests outstanding → the next cycle shows the queue empty, counters 0, `err` 0, and `memresp_rdy`=0.
